// File: rtl/mod_multiplier_barrett_param_pkg.sv
// ---------------------------------------------------------------------------
// mod_multiplier_barrett_param_pkg
// Purpose : shared defaults and width/latency helpers for the parametrised
//           Barrett modular multiplier.
// Contents: default operand width and stage latencies, the base latency
//           helper (mmb_lat) and the K-width helper (mmb_kw).
// Option  : MOD_MULT_BARRETT_CORR2_EN (used by the top) adds one register
//           stage on top of mmb_lat().
// ---------------------------------------------------------------------------
package mod_multiplier_barrett_param_pkg;

    localparam int MMB_DW_DEF     = 32;
    localparam int MMB_LAT_Z_DEF  = 1;
    localparam int MMB_LAT_M2_DEF = 3;
    localparam int MMB_LAT_MQ_DEF = 1;

    // Base latency: three multiplier pipes plus the registered correction.
    function automatic int mmb_lat(input int lat_z, input int lat_m2, input int lat_mq);
        return lat_z + lat_m2 + lat_mq + 1;
    endfunction

    // Bits needed to hold a modulus bit length in the range 1..dw.
    function automatic int mmb_kw(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/mod_multiplier_barrett_param_mult_pp.sv
// ---------------------------------------------------------------------------
// mult_pp_param
// Purpose : unsigned W x W -> 2W multiplier followed by an LAT-deep output
//           pipe. The pipe advances on i_en and is cleared by i_clr
//           (i_clr wins over i_en). LAT must be >= 1.
// Ports   : i_clk   clock, rising edge
//           i_rst_n asynchronous active-low reset
//           i_en    pipe advance
//           i_clr   synchronous clear of every pipe stage
//           i_a/i_b operands (W bits)
//           o_p     product (2W bits), LAT cycles after the operands
// ---------------------------------------------------------------------------
module mult_pp_param #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_en,
    input  logic           i_clr,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);

    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] r_pipe [LAT];

    // Operands are zero-extended so the product is formed at full 2W width.
    assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else if (i_en) begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_p = r_pipe[LAT-1];

endmodule

// File: rtl/mod_multiplier_barrett_param.sv
// ---------------------------------------------------------------------------
// mod_multiplier_barrett_param
// Purpose : pipelined Barrett modular multiplier, oData = (iData0*iData1) mod
//           iMod, with per-transaction modulus/K/U, a valid qualifier, a
//           global stall (iEn) and a synchronous clear (iClr).
// Ports   : iClk, iRstN (async active-low), iEn (advance), iClr (clear, wins
//           over iEn), iValid, iK (bit length of q), iU (floor(4^K/q)),
//           iData0/iData1 (operands < q), iMod (q), oValid, oData.
// Latency : LAT_Z+LAT_M2+LAT_MQ+1 iEn-cycles; +1 when MOD_MULT_BARRETT_CORR2_EN
//           is defined. All LAT_* parameters must be >= 1.
// Option  : MOD_MULT_BARRETT_CORR2_EN -- two registered correction stages
//           (subtract 2q, then q), exact for every t < 3q. Undefined: one
//           correction stage (subtract q), exact for t < 2q.
// ---------------------------------------------------------------------------
module mod_multiplier_barrett_param
    import mod_multiplier_barrett_param_pkg::*;
#(
    parameter int DW     = MMB_DW_DEF,
    parameter int KW     = mmb_kw(DW),
    parameter int LAT_Z  = MMB_LAT_Z_DEF,
    parameter int LAT_M2 = MMB_LAT_M2_DEF,
    parameter int LAT_MQ = MMB_LAT_MQ_DEF
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iEn,
    input  logic            iClr,
    input  logic            iValid,
    input  logic [KW-1:0]   iK,
    input  logic [2*DW-1:0] iU,
    input  logic [DW-1:0]   iData0,
    input  logic [DW-1:0]   iData1,
    input  logic [DW-1:0]   iMod,
    output logic            oValid,
    output logic [DW-1:0]   oData
);

    localparam int L_BASE = mmb_lat(LAT_Z, LAT_M2, LAT_MQ);
`ifdef MOD_MULT_BARRETT_CORR2_EN
    localparam int L_TOT  = L_BASE + 1;
`else
    localparam int L_TOT  = L_BASE;
`endif
    // Stage index (counted in iEn-cycles from input capture) of each tap.
    localparam int S_M3Q  = LAT_Z + LAT_M2;            // m3 and q enter m3*q
    localparam int S_SUB  = LAT_Z + LAT_M2 + LAT_MQ;   // z - m3*q is formed
    localparam int K_DLY  = LAT_Z + LAT_M2;            // K used at m1 and m3
    localparam int U_DLY  = LAT_Z;                     // U used at m2 input
    localparam int Q_DLY  = L_TOT - 1;                 // q reaches final correction
    localparam int ZD_DLY = LAT_M2 + LAT_MQ;           // z from its pipe to subtract

    // Sideband delay lines; index i holds the value captured i iEn-cycles ago.
    logic [KW-1:0]   r_k   [1:K_DLY];
    logic [2*DW-1:0] r_u   [1:U_DLY];
    logic [DW-1:0]   r_q   [1:Q_DLY];
    logic [2*DW-1:0] r_zd  [1:ZD_DLY];
    logic            r_vld [1:L_TOT];
    logic [DW-1:0]   r_odata;

    logic [2*DW-1:0] w_z;
    logic [2*DW-1:0] w_m1;
    logic [4*DW-1:0] w_m2;
    logic [DW-1:0]   w_m3;
    logic [2*DW-1:0] w_m3q;
    logic [2*DW-1:0] w_t;
    logic [2*DW-1:0] w_fin_t;
    logic [2*DW-1:0] w_fin_q;
    logic [2*DW-1:0] w_fin_o;

    // ---------------------------------------------------------------- datapath
    mult_pp_param #(.W(DW), .LAT(LAT_Z)) u_mul_z (
        .i_clk   (iClk),
        .i_rst_n (iRstN),
        .i_en    (iEn),
        .i_clr   (iClr),
        .i_a     (iData0),
        .i_b     (iData1),
        .o_p     (w_z)
    );

    assign w_m1 = w_z >> r_k[LAT_Z];

    mult_pp_param #(.W(2*DW), .LAT(LAT_M2)) u_mul_m2 (
        .i_clk   (iClk),
        .i_rst_n (iRstN),
        .i_en    (iEn),
        .i_clr   (iClr),
        .i_a     (w_m1),
        .i_b     (r_u[U_DLY]),
        .o_p     (w_m2)
    );

    // For in-range operands m3 <= z/q < q < 2^DW, so the low DW bits are exact.
    assign w_m3 = DW'(w_m2 >> r_k[K_DLY]);

    mult_pp_param #(.W(DW), .LAT(LAT_MQ)) u_mul_mq (
        .i_clk   (iClk),
        .i_rst_n (iRstN),
        .i_en    (iEn),
        .i_clr   (iClr),
        .i_a     (w_m3),
        .i_b     (r_q[S_M3Q]),
        .o_p     (w_m3q)
    );

    // Wraps mod 2^(2DW); for in-range operands the true t lies in [0, 3q).
    assign w_t = r_zd[ZD_DLY] - w_m3q;

`ifdef MOD_MULT_BARRETT_CORR2_EN
    logic [2*DW-1:0] w_q2;
    logic [2*DW-1:0] w_t1;
    logic [2*DW-1:0] r_t1;

    assign w_q2 = {{(DW-1){1'b0}}, r_q[S_SUB], 1'b0};
    assign w_t1 = (w_t >= w_q2) ? (w_t - w_q2) : w_t;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)      r_t1 <= '0;
        else if (iClr)   r_t1 <= '0;
        else if (iEn)    r_t1 <= w_t1;
    end

    assign w_fin_t = r_t1;
`else
    assign w_fin_t = w_t;
`endif

    // Q_DLY lands on the same stage as w_fin_t in both builds.
    assign w_fin_q = {{DW{1'b0}}, r_q[Q_DLY]};
    assign w_fin_o = (w_fin_t >= w_fin_q) ? (w_fin_t - w_fin_q) : w_fin_t;

    // ------------------------------------------------------- sideband lines
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 1; i <= K_DLY;  i++) r_k[i]  <= '0;
            for (int i = 1; i <= U_DLY;  i++) r_u[i]  <= '0;
            for (int i = 1; i <= Q_DLY;  i++) r_q[i]  <= '0;
            for (int i = 1; i <= ZD_DLY; i++) r_zd[i] <= '0;
        end else if (iClr) begin
            for (int i = 1; i <= K_DLY;  i++) r_k[i]  <= '0;
            for (int i = 1; i <= U_DLY;  i++) r_u[i]  <= '0;
            for (int i = 1; i <= Q_DLY;  i++) r_q[i]  <= '0;
            for (int i = 1; i <= ZD_DLY; i++) r_zd[i] <= '0;
        end else if (iEn) begin
            r_k[1]  <= iK;
            r_u[1]  <= iU;
            r_q[1]  <= iMod;
            r_zd[1] <= w_z;
            for (int i = 2; i <= K_DLY;  i++) r_k[i]  <= r_k[i-1];
            for (int i = 2; i <= U_DLY;  i++) r_u[i]  <= r_u[i-1];
            for (int i = 2; i <= Q_DLY;  i++) r_q[i]  <= r_q[i-1];
            for (int i = 2; i <= ZD_DLY; i++) r_zd[i] <= r_zd[i-1];
        end
    end

    // ------------------------------------------------------ valid and output
    // Bubbles advance through r_vld; oData only loads a valid result, so it
    // holds the last valid value across bubbles and stalls.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 1; i <= L_TOT; i++) r_vld[i] <= 1'b0;
            r_odata <= '0;
        end else if (iClr) begin
            for (int i = 1; i <= L_TOT; i++) r_vld[i] <= 1'b0;
            r_odata <= '0;
        end else if (iEn) begin
            r_vld[1] <= iValid;
            for (int i = 2; i <= L_TOT; i++) r_vld[i] <= r_vld[i-1];
            if (r_vld[L_TOT-1]) r_odata <= DW'(w_fin_o);
        end
    end

    assign oValid = r_vld[L_TOT];
    assign oData  = r_odata;

endmodule

// File: tb/tb_mod_multiplier_barrett_param.sv
// ---------------------------------------------------------------------------
// tb_mod_multiplier_barrett_param
// Directed steps followed by a randomized sweep. A behavioural model keeps
// each accepted transaction's expected result and its age in iEn-cycles; a
// result is due at the output once its age reaches the latency. oData is
// expected to hold the last due result (0 after reset/clear).
// Build option: MOD_MULT_BARRETT_CORR2_EN (latency +1, exact (a*b) mod q).
// ---------------------------------------------------------------------------
module tb_mod_multiplier_barrett_param;

    localparam int DW = 32;
    localparam int KW = 6;
`ifdef MOD_MULT_BARRETT_CORR2_EN
    localparam int LT = 7;
`else
    localparam int LT = 6;
`endif
    localparam int NRAND = 3000;

    logic            iClk;
    logic            iRstN;
    logic            iEn;
    logic            iClr;
    logic            iValid;
    logic [KW-1:0]   iK;
    logic [2*DW-1:0] iU;
    logic [DW-1:0]   iData0;
    logic [DW-1:0]   iData1;
    logic [DW-1:0]   iMod;
    logic            oValid;
    logic [DW-1:0]   oData;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    int            age_q[$];
    logic          exp_vld;
    logic [DW-1:0] exp_dat;

    mod_multiplier_barrett_param dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iValid (iValid),
        .iK     (iK),
        .iU     (iU),
        .iData0 (iData0),
        .iData1 (iData1),
        .iMod   (iMod),
        .oValid (oValid),
        .oData  (oData)
    );

    // ------------------------------------------------------ clock and reset
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // ------------------------------------------------------------ reference
    function automatic int bitlen(input logic [DW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DW; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] q);
        logic [127:0] z;
        z = 128'(a) * 128'(b);
`ifdef MOD_MULT_BARRETT_CORR2_EN
        return DW'(z % 128'(q));
`else
        begin
            logic [127:0] u;
            logic [127:0] m3;
            logic [127:0] t;
            int k;
            k  = bitlen(q);
            u  = (128'd1 << (2 * k)) / 128'(q);
            m3 = ((z >> k) * u) >> k;
            t  = z - m3 * 128'(q);
            if (t >= 128'(q)) t = t - 128'(q);
            return DW'(t);
        end
`endif
    endfunction

    function automatic logic [DW-1:0] rand_q();
        int k;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        k  = $urandom_range(32, 2);
        lo = 32'd1 << (k - 1);
        hi = (k == 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
        return $urandom_range(hi, lo);
    endfunction

    // ------------------------------------------------------------ checking
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        age_q.delete();
        exp_vld = 1'b0;
        exp_dat = '0;
    endtask

    // One clock: update the model with the inputs sampled at this edge, then
    // compare both outputs 1 time unit later.
    task automatic cycle();
        @(posedge iClk);
        if (!iRstN || iClr) begin
            model_clear();
        end else if (iEn) begin
            for (int i = 0; i < age_q.size(); i++) age_q[i]++;
            if (iValid) begin
                exp_q.push_back(model(iData0, iData1, iMod));
                age_q.push_back(1);
            end
            if (age_q.size() > 0 && age_q[0] == LT) begin
                exp_vld = 1'b1;
                exp_dat = exp_q.pop_front();
                void'(age_q.pop_front());
            end else begin
                exp_vld = 1'b0;
            end
        end
        #1;
        check("ovalid", 32'(oValid), 32'(exp_vld));
        check("odata", oData, exp_dat);
    endtask

    // ---------------------------------------------------------------- driver
    task automatic step(input logic en, input logic clr, input logic v,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] q);
        iEn    = en;
        iClr   = clr;
        iValid = v;
        iData0 = a;
        iData1 = b;
        iMod   = q;
        iK     = KW'(bitlen(q));
        iU     = 64'((128'd1 << (2 * bitlen(q))) / 128'(q));
        cycle();
    endtask

    task automatic step_rand(input logic en, input logic clr, input logic v);
        logic [DW-1:0] q;
        q = rand_q();
        step(en, clr, v, $urandom_range(q - 1, 0), $urandom_range(q - 1, 0), q);
    endtask

    // ---------------------------------------------------------------- steps
    initial begin
        logic [DW-1:0] qbig;
        qbig = 32'd4294967291;
        model_clear();
        iRstN = 1'b1; iEn = 1'b0; iClr = 1'b0; iValid = 1'b0;
        iData0 = '0; iData1 = '0; iMod = 32'd2; iK = 6'd2; iU = 64'd8;
        #1 iRstN = 1'b0;
        #2;
        check("reset_ovalid", 32'(oValid), 32'd0);
        check("reset_odata", oData, 32'd0);
        repeat (2) cycle();
        @(negedge iClk) iRstN = 1'b1;

        // Small modulus, single pulse; explicit latency and value.
        step(1'b1, 1'b0, 1'b1, 32'd50, 32'd60, 32'd97);
        repeat (LT - 1) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd97);
        check("t1_ovalid", 32'(oValid), 32'd1);
        check("t1_odata", oData, 32'd90);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd97);
        check("t1_pulse_end", 32'(oValid), 32'd0);

        // Max-width modulus, a = b = q-1.
        step(1'b1, 1'b0, 1'b1, qbig - 1, qbig - 1, qbig);
        repeat (LT - 1) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, qbig);
        check("t2_ovalid", 32'(oValid), 32'd1);
        check("t2_odata", oData, 32'd1);

        // Back-to-back, modulus alternating every transaction.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b0, 1'b1, $urandom_range(96, 0), $urandom_range(96, 0), 32'd97);
            else            step(1'b1, 1'b0, 1'b1, $urandom_range(qbig - 1, 0), $urandom_range(qbig - 1, 0), qbig);
        end
        repeat (LT + 1) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd97);

        // Stall mid-stream; iValid asserted during the stall must be ignored.
        repeat (4) step_rand(1'b1, 1'b0, 1'b1);
        repeat (3) step_rand(1'b0, 1'b0, 1'b1);
        repeat (3) step_rand(1'b1, 1'b0, 1'b1);
        repeat (3) step_rand(1'b0, 1'b0, 1'b0);
        repeat (LT + 1) step_rand(1'b1, 1'b0, 1'b0);

        // Clear with four transactions in flight.
        repeat (4) step_rand(1'b1, 1'b0, 1'b1);
        step_rand(1'b1, 1'b1, 1'b1);
        check("clr_ovalid", 32'(oValid), 32'd0);
        check("clr_odata", oData, 32'd0);
        repeat (LT + 1) step_rand(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-stream.
        repeat (LT) step_rand(1'b1, 1'b0, 1'b1);
        #2 iRstN = 1'b0;
        #1;
        check("rst_async_ovalid", 32'(oValid), 32'd0);
        check("rst_async_odata", oData, 32'd0);
        model_clear();
        cycle();
        iRstN = 1'b1;
        step(1'b1, 1'b0, 1'b1, 32'd50, 32'd60, 32'd97);
        repeat (LT - 1) step_rand(1'b1, 1'b0, 1'b0);
        check("rst_first_ovalid", 32'(oValid), 32'd1);
        check("rst_first_odata", oData, 32'd90);
        repeat (2) step_rand(1'b1, 1'b0, 1'b0);

        // Randomized sweep with bubbles, stalls and rare clears.
        for (int n = 0; n < NRAND; n++) begin
            step_rand($urandom_range(9, 0) != 0, $urandom_range(199, 0) == 0,
                      $urandom_range(3, 0) != 0);
        end
        repeat (LT + 2) step_rand(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
